// File: rtl/bpsk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_pkg
// Brief    : Shared types, symbol constants and bit-to-symbol mapping for the
//            BPSK transmit path (scheduler and mapper).
// Revision : 1.0 - initial release
// ============================================================================
package bpsk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] SYM_POS  = 2'b01;
    localparam logic [1:0] SYM_NEG  = 2'b11;
    localparam logic [1:0] SYM_ZERO = 2'b00;

    // Bit 0 maps to +1, bit 1 maps to -1.
    function automatic logic [1:0] bpsk_map(input logic b);
        return b ? SYM_NEG : SYM_POS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bpsk_symbol_timer.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_symbol_timer
// Brief    : Clock divider for symbol pacing. div_cnt counts 0..SYM_DIV-1
//            and wraps; clr forces it back to 0 on the next edge.
//            sym_tick_last : current cycle is the last of a symbol.
//            sym_tick_first: the coming cycle is the first of a symbol
//                            (used to produce a registered strobe).
// Revision : 1.0 - initial release
// ============================================================================
module bpsk_symbol_timer #(
    parameter int SYM_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic sym_tick_first,
    output logic sym_tick_last
);

    localparam int                  c_div_w    = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SYM_DIV - 1);

    logic [c_div_w-1:0] r_div_cnt;

    // Divider counter: clear has priority, otherwise wrap at SYM_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (clr || (r_div_cnt == c_div_last)) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign sym_tick_last  = (r_div_cnt == c_div_last);
    assign sym_tick_first = clr || sym_tick_last;

endmodule
`default_nettype wire

// File: rtl/bpsk_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_symbol_scheduler
// Brief    : Accepts N-bit codewords over valid/ready and serialises them
//            LSB-first into 2-bit BPSK symbols, each held SYM_DIV cycles.
//            Build macro BPSK_PREAMBLE_EN: when defined, an alternating
//            PRE_LEN-symbol preamble precedes every burst.
// Revision : 1.0 - initial release
// ============================================================================
module bpsk_symbol_scheduler
    import bpsk_pkg::*;
#(
    parameter int N       = 8,
    parameter int SYM_DIV = 4,
    parameter int PRE_LEN = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] cw_data,
    input  logic         cw_valid,
    output logic         cw_ready,
    output logic [1:0]   sym_out,
    output logic         sym_valid,
    output logic         sym_strobe,
    output logic         frame_start,
    output logic         busy
);

    localparam int                 c_max_len  = (N > PRE_LEN) ? N : PRE_LEN;
    localparam int                 c_idx_w    = (c_max_len > 1) ? $clog2(c_max_len) : 1;
    localparam logic [c_idx_w-1:0] c_data_last = c_idx_w'(N - 1);
`ifdef BPSK_PREAMBLE_EN
    localparam logic [c_idx_w-1:0] c_pre_last  = c_idx_w'(PRE_LEN - 1);
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic [c_idx_w-1:0] r_sym_idx;
    logic [c_idx_w-1:0] w_idx_next;
    logic [N-1:0]       r_cw_data_q;
    logic [N-1:0]       w_data_next;
    logic               w_data_bit;
    logic [1:0]         w_sym_next;
    logic [1:0]         r_sym_out;
    logic               r_sym_valid;
    logic               r_sym_strobe;
    logic               r_frame_start;
    logic               r_busy;
    logic               w_enter;
    logic               w_div_clr;
    logic               w_tick_first;
    logic               w_tick_last;
    logic               w_last_data;
    logic               w_cw_ready;
    logic               w_xfer;

    bpsk_symbol_timer #(
        .SYM_DIV (SYM_DIV)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (w_div_clr),
        .sym_tick_first (w_tick_first),
        .sym_tick_last  (w_tick_last)
    );

    // Ready is a pure decode of registered state: idle, or final cycle of the last data symbol.
    assign w_last_data = (r_state == DATA) && w_tick_last && (r_sym_idx == c_data_last);
    assign w_cw_ready  = (r_state == IDLE) || w_last_data;
    assign w_xfer      = cw_valid && w_cw_ready;
    assign w_div_clr   = w_enter || (r_state == IDLE);

    // Next-state decode; w_enter flags every state entry (including DATA re-entry).
    always_comb begin
        w_state_next = r_state;
        w_enter      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
`ifdef BPSK_PREAMBLE_EN
                    w_state_next = PRE;
`else
                    w_state_next = DATA;
`endif
                    w_enter = 1'b1;
                end
            end
`ifdef BPSK_PREAMBLE_EN
            PRE: begin
                if (w_tick_last && (r_sym_idx == c_pre_last)) begin
                    w_state_next = DATA;
                    w_enter      = 1'b1;
                end
            end
`endif
            DATA: begin
                if (w_last_data) begin
                    w_state_next = w_xfer ? DATA : IDLE;
                    w_enter      = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_enter      = 1'b1;
            end
        endcase
    end

    // Symbol index: cleared on entry and while idle, advanced at each symbol end.
    always_comb begin
        w_idx_next = r_sym_idx;
        if (w_enter || (r_state == IDLE)) begin
            w_idx_next = '0;
        end else if (w_tick_last) begin
            w_idx_next = r_sym_idx + 1'b1;
        end
    end

    // Symbol that will be on the wire next cycle, from the next state/index/word.
    always_comb begin
        w_data_next = w_xfer ? cw_data : r_cw_data_q;
        w_data_bit  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_idx_next == c_idx_w'(i)) begin
                w_data_bit = w_data_next[i];
            end
        end
        w_sym_next = SYM_ZERO;
        case (w_state_next)
`ifdef BPSK_PREAMBLE_EN
            PRE:     w_sym_next = bpsk_map(w_idx_next[0]);
`endif
            DATA:    w_sym_next = bpsk_map(w_data_bit);
            default: w_sym_next = SYM_ZERO;
        endcase
    end

    // State, index, capture register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_sym_idx     <= '0;
            r_cw_data_q   <= '0;
            r_sym_out     <= SYM_ZERO;
            r_sym_valid   <= 1'b0;
            r_sym_strobe  <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_sym_idx     <= w_idx_next;
            r_cw_data_q   <= w_data_next;
            r_sym_out     <= w_sym_next;
            r_sym_valid   <= (w_state_next != IDLE);
            r_sym_strobe  <= (w_state_next != IDLE) && w_tick_first;
            r_frame_start <= w_xfer;
            r_busy        <= (w_state_next != IDLE);
        end
    end

    assign cw_ready    = w_cw_ready;
    assign sym_out     = r_sym_out;
    assign sym_valid   = r_sym_valid;
    assign sym_strobe  = r_sym_strobe;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bpsk_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpsk_symbol_scheduler
// Brief    : Directed, table-driven bench for bpsk_symbol_scheduler with an
//            N=8/SYM_DIV=4 instance and an N=15/SYM_DIV=1 instance.
//            Honours BPSK_PREAMBLE_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpsk_symbol_scheduler;

    localparam int N  = 8;
    localparam int SD = 4;
`ifdef BPSK_PREAMBLE_EN
    localparam int PRE   = 8;
    localparam int PRE15 = 8;
`else
    localparam int PRE   = 0;
    localparam int PRE15 = 0;
`endif
    localparam logic [6:0] IDLE_OBS = 7'b00_0000_1;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cw_data;
    logic        cw_valid;
    logic        cw_ready;
    logic [1:0]  sym_out;
    logic        sym_valid;
    logic        sym_strobe;
    logic        frame_start;
    logic        busy;

    logic [14:0] cw_data15;
    logic        cw_valid15;
    logic        cw_ready15;
    logic [1:0]  sym_out15;
    logic        sym_valid15;
    logic        sym_strobe15;
    logic        frame_start15;
    logic        busy15;

    int n_pass;
    int n_total;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] exp_syms;   // symbol i in bits [2i+1:2i]
    } vec_t;

    vec_t vecs[5];

    bpsk_symbol_scheduler #(.N(8), .SYM_DIV(4), .PRE_LEN(8)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cw_data     (cw_data),
        .cw_valid    (cw_valid),
        .cw_ready    (cw_ready),
        .sym_out     (sym_out),
        .sym_valid   (sym_valid),
        .sym_strobe  (sym_strobe),
        .frame_start (frame_start),
        .busy        (busy)
    );

    bpsk_symbol_scheduler #(.N(15), .SYM_DIV(1), .PRE_LEN(8)) u_dut15 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cw_data     (cw_data15),
        .cw_valid    (cw_valid15),
        .cw_ready    (cw_ready15),
        .sym_out     (sym_out15),
        .sym_valid   (sym_valid15),
        .sym_strobe  (sym_strobe15),
        .frame_start (frame_start15),
        .busy        (busy15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] obs();
        return {sym_out, sym_valid, sym_strobe, frame_start, busy, cw_ready};
    endfunction

    function automatic logic [6:0] obs15();
        return {sym_out15, sym_valid15, sym_strobe15, frame_start15, busy15, cw_ready15};
    endfunction

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {sym,vld,stb,fs,busy,rdy}=%b expected %b", nm, act, exp);
    endtask

    // Checks one frame cycle by cycle, starting on its first symbol cycle.
    // present_k >= 0 raises cw_valid with next_data at that frame cycle.
    task automatic check_frame(input logic [15:0] exp, input int pre, input int ncyc,
                               input int present_k, input logic [7:0] next_data,
                               input string nm);
        int len;
        len = (pre + N) * SD;
        for (int k = 0; k < len && k < ncyc; k++) begin
            int s;
            int ph;
            logic [1:0] sym;
            if (k == present_k) begin
                cw_valid = 1'b1;
                cw_data  = next_data;
            end
            s  = k / SD;
            ph = k % SD;
            if (s < pre) sym = (s % 2 == 1) ? 2'b11 : 2'b01;
            else         sym = exp[2*(s-pre) +: 2];
            check($sformatf("%s c%0d", nm, k), obs(),
                  {sym, 1'b1, (ph == 0), (k == 0), 1'b1,
                   (s == pre + N - 1) && (ph == SD - 1)});
            tick();
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        vecs[0] = '{data: 8'hA5, exp_syms: 16'hDD77};
        vecs[1] = '{data: 8'h00, exp_syms: 16'h5555};
        vecs[2] = '{data: 8'hFF, exp_syms: 16'hFFFF};
        vecs[3] = '{data: 8'h3C, exp_syms: 16'h5FF5};
        vecs[4] = '{data: 8'h01, exp_syms: 16'h5557};

        rst_n      = 1'b0;
        cw_valid   = 1'b0;
        cw_data    = 8'h00;
        cw_valid15 = 1'b0;
        cw_data15  = 15'h0;
        repeat (3) tick();
        check("reset", obs(), IDLE_OBS);
        check("reset15", obs15(), IDLE_OBS);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_reset", obs(), IDLE_OBS);

        // Single words from the vector table.
        for (int v = 0; v < 5; v++) begin
            cw_data  = vecs[v].data;
            cw_valid = 1'b1;
            tick();
            cw_valid = 1'b0;
            cw_data  = 8'h00;
            check_frame(vecs[v].exp_syms, PRE, 1000, -1, 8'h00, $sformatf("vec%0d", v));
            check($sformatf("vec%0d idle", v), obs(), IDLE_OBS);
            tick();
        end

        // Back-to-back: 00 then FF with cw_valid held throughout.
        cw_data  = 8'h00;
        cw_valid = 1'b1;
        tick();
        cw_data = 8'hFF;
        check_frame(16'h5555, PRE, 1000, -1, 8'h00, "b2b_w0");
        cw_valid = 1'b0;
        check_frame(16'hFFFF, 0, 1000, -1, 8'h00, "b2b_w1");
        check("b2b idle", obs(), IDLE_OBS);
        tick();

        // Backpressure: 3C offered mid-frame, must wait for the word boundary.
        cw_data  = 8'h01;
        cw_valid = 1'b1;
        tick();
        cw_valid = 1'b0;
        check_frame(16'h5557, PRE, 1000, (PRE + 3) * SD + 1, 8'h3C, "bp_w0");
        cw_valid = 1'b0;
        check_frame(16'h5FF5, 0, 1000, -1, 8'h00, "bp_w1");
        check("bp idle", obs(), IDLE_OBS);
        tick();
        check("bp no_dup", obs(), IDLE_OBS);

        // Reset 20 cycles into the data phase.
        cw_data  = 8'hA5;
        cw_valid = 1'b1;
        tick();
        cw_valid = 1'b0;
        check_frame(16'hDD77, PRE, PRE * SD + 20, -1, 8'h00, "rst_mid");
        rst_n = 1'b0;
        #1;
        check("rst async", obs(), IDLE_OBS);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst released", obs(), IDLE_OBS);
        tick();
        check("rst no_resume", obs(), IDLE_OBS);
        cw_data  = 8'h01;
        cw_valid = 1'b1;
        tick();
        cw_valid = 1'b0;
        check_frame(16'h5557, PRE, 1000, -1, 8'h00, "after_rst");
        check("after_rst idle", obs(), IDLE_OBS);

        // N=15, SYM_DIV=1: 15'h4001 -> 11, 01 x13, 11 on consecutive cycles.
        cw_data15  = 15'h4001;
        cw_valid15 = 1'b1;
        tick();
        cw_valid15 = 1'b0;
        cw_data15  = 15'h0;
        for (int k = 0; k < PRE15 + 15; k++) begin
            logic [1:0] sym;
            if (k < PRE15)                            sym = (k % 2 == 1) ? 2'b11 : 2'b01;
            else if (k == PRE15 || k == PRE15 + 14)   sym = 2'b11;
            else                                      sym = 2'b01;
            check($sformatf("n15 c%0d", k), obs15(),
                  {sym, 1'b1, 1'b1, (k == 0), 1'b1, (k == PRE15 + 14)});
            tick();
        end
        check("n15 idle", obs15(), IDLE_OBS);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bpsk_symbol_scheduler.md
# bpsk_symbol_scheduler

Sequencing controller in front of the BPSK mapper. It accepts N-bit codewords from the Hamming (N=8) or BCH (N=15) encoder over a valid/ready handshake. It serializes each codeword LSB-first into 2-bit BPSK symbols (+1 = 2'b01, −1 = 2'b11, zero = 2'b00) at a programmable symbol rate. A fixed preamble is prepended at the start of each burst.

## Interface
- N, 8, codeword width in bits (8 Hamming, 15 BCH); legal 1..15
- SYM_DIV, 4, clock cycles per symbol; legal ≥1
- PRE_LEN, 8, preamble length in symbols; legal ≥1 (used only with BPSK_PREAMBLE_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cw_data  in  N  codeword; bit 0 is transmitted first
- cw_valid  in  1  codeword present
- cw_ready  out  1  scheduler can accept a codeword this cycle
- sym_out  out  2  current symbol: 01 (+1), 11 (−1), 00 (idle)
- sym_valid  out  1  sym_out carries a preamble or data symbol
- sym_strobe  out  1  one-cycle pulse on the first cycle of every symbol
- frame_start  out  1  one-cycle pulse on the first symbol of each accepted codeword (the first preamble symbol if a preamble precedes it)
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: sym_out=00, sym_valid=0, cw_ready=1.
  - PRE: preamble, PRE_LEN symbols; preamble bit k = k mod 2, mapped 0→01, 1→11, so the sequence is 01,11,01,…
  - DATA: N symbols; symbol i = map(cw_data_q[i]).
- Transfer occurs when cw_valid && cw_ready. The word is captured in cw_data_q; cw_data is not sampled afterwards.
- Transitions:
  - IDLE→PRE on transfer.
  - PRE→DATA after the final cycle of preamble symbol PRE_LEN−1.
  - DATA→DATA (new word, no preamble) when a transfer occurs on the last cycle of symbol N−1.
  - DATA→IDLE otherwise.
- cw_ready is 1 in IDLE and on the last cycle of DATA symbol N−1 (div_cnt==SYM_DIV−1 && sym_idx==N−1); it is 0 at all other times.
- Counters:
  - div_cnt runs 0..SYM_DIV−1 and wraps.
  - sym_idx runs 0..max(N,PRE_LEN)−1; width is $clog2 of that maximum, minimum 1 bit.
  - Both counters clear on every state entry.
- A cw_valid held high while cw_ready=0 has no effect. The producer keeps cw_data stable until the transfer.

## Timing
- Reset values: state IDLE, sym_out=00, sym_valid=0, sym_strobe=0, frame_start=0, busy=0, cw_ready=1, all counters 0.
- All outputs except cw_ready are registered.
- cw_ready is a combinational decode of the state and counter registers only. It has no path from cw_valid.
- A transfer in cycle T places the first symbol on sym_out in cycle T+1, with sym_strobe=1, frame_start=1 and sym_valid=1.
- Each symbol is held for exactly SYM_DIV cycles. With SYM_DIV=1, sym_strobe stays high throughout the frame.
- Back-to-back words: the first symbol of the next word follows the last symbol of the previous word with no gap. frame_start pulses again.
- A burst with preamble lasts (PRE_LEN+N)·SYM_DIV cycles. It returns to IDLE (sym_out=00) in the following cycle.
- Asserting rst_n low at any point clears all state immediately. The in-flight codeword is discarded, and no partial frame resumes after reset.

## Configuration
- BPSK_PREAMBLE_EN defined:
  - PRE state and PRE_LEN are active.
  - IDLE→PRE on transfer.
- BPSK_PREAMBLE_EN undefined:
  - PRE state is not compiled in.
  - IDLE→DATA on transfer.
  - frame_start marks data symbol 0.
  - PRE_LEN is ignored.

## Structure
- Package bpsk_pkg:
  - state enum {IDLE, PRE, DATA}
  - constants SYM_POS=2'b01, SYM_NEG=2'b11, SYM_ZERO=2'b00
  - function bpsk_map(bit)→2-bit symbol, shared with the mapper
- Sub-module bpsk_symbol_timer:
  - contains div_cnt with a clear input
  - emits sym_tick_last (div_cnt==SYM_DIV−1) and sym_tick_first
- The FSM, index counter and capture register remain in the top module.

## Test plan
- Reset: hold rst_n=0, toggle clk → sym_out=00, sym_valid=0, busy=0, cw_ready=1; after release, same values until the first transfer.
- Single word, preamble on (N=8, SYM_DIV=4, PRE_LEN=8), cw_data=8'hA5 transferred at T:
  - T+1..T+32: 01,11,… alternating every 4 cycles.
  - T+33..T+64: 11,01,11,01,01,11,01,11.
  - T+65: sym_out=00, busy=0.
  - frame_start high only at T+1.
- Back-to-back: 8'h00 then 8'hFF with cw_valid held → 32 cycles of 01 then 32 cycles of 11 after the preamble, with no second preamble. cw_ready is high for exactly one cycle between the words, and frame_start pulses twice.
- Backpressure: present 8'h3C at preamble symbol 3 → cw_ready stays 0 until the last cycle of the current word. The word transfers there, with no drop and no duplication.
- Reset mid-frame: pull rst_n low 20 cycles into DATA → sym_out=00 asynchronously. After release, state is IDLE and the next word starts with a full preamble.
- N=15, SYM_DIV=1, macro undefined, cw_data=15'h4001 → symbols 11, then 01×13, then 11 on 15 consecutive cycles. sym_strobe stays high for all 15, and cw_ready is high in the 15th cycle.
